axi_handshake_monitor: RTL and testbench
========================================

# axi_handshake_monitor

Parametrised, port-based AXI4 protocol monitor for all five channels (AW, W, B, AR, R). It checks VALID/payload stability while a transfer is stalled, burst-length consistency of WLAST/RLAST against the issued AxLEN, and, optionally, stall timeouts. It sits beside any AXI master/slave pair in the testbench, or in an FPGA debug build. It reports each violation as a registered error event plus saturating counters instead of stopping the simulation.

## Interface
Parameters:
- AW_INFO_W, 64: width of concatenated AW payload excluding len (addr, id, size, burst…).
- W_INFO_W, 36: width of W payload excluding last (data, strb).
- B_INFO_W, 10: width of B payload (id, resp).
- AR_INFO_W, 64: width of AR payload excluding len.
- R_INFO_W, 42: width of R payload excluding last (data, id, resp).
- LEN_FIFO_DEPTH, 8: outstanding-burst length FIFO depth per direction; power of 2, ≥2.
- TIMEOUT_CYCLES, 1024: stall limit, ≥2; used only with AXI_MON_TIMEOUT_EN.
- ERR_CNT_W, 16: error counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- aw_valid, aw_ready  in  1  AW handshake.
- aw_len  in  8  AWLEN.
- aw_info  in  AW_INFO_W  remaining AW payload.
- w_valid, w_ready, w_last  in  1  W handshake and WLAST.
- w_info  in  W_INFO_W  W payload.
- b_valid, b_ready  in  1  B handshake.
- b_info  in  B_INFO_W  B payload.
- ar_valid, ar_ready  in  1  AR handshake.
- ar_len  in  8  ARLEN.
- ar_info  in  AR_INFO_W  remaining AR payload.
- r_valid, r_ready, r_last  in  1  R handshake and RLAST.
- r_info  in  R_INFO_W  R payload.
- err_valid  out  1  one-cycle pulse: an error was detected.
- err_chan  out  3  channel: 0 AW, 1 W, 2 B, 3 AR, 4 R.
- err_code  out  4  error code (see Operation).
- err_multi  out  1  more than one error was detected in the same cycle.
- err_count  out  ERR_CNT_W  saturating count of cycles with ≥1 error.
- err_sticky  out  1  set on the first error, cleared only by reset.

## Operation
- Per channel: registered copies of valid, ready and payload (including len/last) from the previous cycle.
- Stall check (every channel): if the previous cycle had valid=1 and ready=0:
  - current valid=0 → code 0x1 (valid dropped);
  - any payload bit differs (`!==`, X-sensitive) → code 0x2 (payload changed).
  - If both occur, report 0x1.
- Write length tracking:
  - AW handshake pushes aw_len into the W-FIFO.
  - W beat counter wcnt increments on each W handshake.
  - W beat with wcnt == head len and w_last=1: pop the FIFO, wcnt←0, no error.
  - w_last=1 with wcnt < head len → 0x3 (WLAST early); pop and clear.
  - wcnt == head len with w_last=0 → 0x4 (WLAST missing); counter keeps running, no pop.
  - W-before-AW is legal. While the FIFO is empty, beats are counted and the check is deferred (state W_WAIT). When the first AW handshake arrives, the check is evaluated against the incoming aw_len in that cycle.
- Read length tracking:
  - AR handshake pushes into the R-FIFO; rcnt counts R handshakes.
  - 0x5 (RLAST early) and 0x6 (RLAST missing) use the same rules as W.
  - R handshake with the R-FIFO empty (and no same-cycle AR push) → 0x9.
  - The read check assumes in-order responses.
- A push into a full FIFO → 0x8 (overflow) on that channel; the push is dropped.
- Simultaneous push and pop on a full FIFO is legal.
- Reporting:
  - Lowest channel number wins; within a channel, the lowest code wins.
  - err_multi=1 if any other error was also detected that cycle.
  - err_count increments by 1 per error cycle and saturates at all-ones.

## Timing
- All outputs are registered. The error is reported on the cycle after the clock edge at which the violation is sampled.
- Reset values: err_valid 0, err_chan 0, err_code 0, err_multi 0, err_count 0, err_sticky 0.
- Reset also clears FIFOs, beat counters and W_WAIT, and sets all previous-cycle valid copies to 0.
- First cycle after reset release: no stall check fires.
- Reset mid-burst discards all tracking; no error is reported for the aborted burst.
- FIFO state: push and pop in the same cycle leave the occupancy unchanged. An empty FIFO with a same-cycle push bypasses the value to the checker.

## Configuration
- AXI_MON_TIMEOUT_EN defined:
  - Each channel has a stall counter that increments while valid=1 and ready=0, and clears on handshake or when valid=0.
  - When it reaches TIMEOUT_CYCLES, report code 0x7 once. The counter then holds until it clears.
- Undefined: no stall counters are built, and code 0x7 is never produced.

## Test plan
- AW held valid with ready=0 for 3 cycles; aw_info changes in cycle 2 → err_valid=1, err_chan=0, err_code=0x2, one cycle later; err_count=1.
- AW len=3 issued, then 4 W beats with w_last on the 4th → no error. Repeat with w_last on the 2nd → err_chan=1, code=0x3.
- 2 W beats (last on the 2nd) sent before AW len=1 → no error. The same with AW len=3 → code 0x3 in the AW handshake cycle.
- R beat with no AR outstanding → err_chan=4, code=0x9. Nine AR pushes with LEN_FIFO_DEPTH=8 and no R → code 0x8 on err_chan=3.
- AR valid dropped after a stall and W payload changed in the same cycle → err_chan=1, code=0x2, err_multi=1.
- With AXI_MON_TIMEOUT_EN, TIMEOUT_CYCLES=16: B stalled for 40 cycles → exactly one code 0x7 pulse on err_chan=2. Without the macro → no error.

Source files
------------

// File: rtl/axi_handshake_monitor.sv
// AXI4 five-channel handshake monitor: stall stability, burst length, optional stall timeout.
// Ports: clk, rst_n, AW/W/B/AR/R handshake+payload in; err_valid/chan/code/multi/count/sticky out.
// Optional stall timeout is built when the AXI_MON_TIMEOUT_EN macro is defined.

module axi_handshake_monitor_len_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic       empty,
   output logic [7:0] head,
   output logic       ovf
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULLV = (PW+1)'(DEPTH);

   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic [7:0]    mem_q [DEPTH];
   logic          wr;

   always_comb begin
      empty = (cnt_q == '0);
      // empty FIFO forwards a same-cycle push straight to the checker
      head  = empty ? din : mem_q[rptr_q];
      ovf   = push & (cnt_q == FULLV) & ~pop;
      wr    = push & ~ovf;
      wptr_d = wr ? wptr_q + 1'b1 : wptr_q;
      rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
      unique case ({wr, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rptr_q <= '0;
         wptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem_q[wptr_q] <= din;
   end
endmodule

module axi_handshake_monitor #(
   parameter int AW_INFO_W      = 64,
   parameter int W_INFO_W       = 36,
   parameter int B_INFO_W       = 10,
   parameter int AR_INFO_W      = 64,
   parameter int R_INFO_W       = 42,
   parameter int LEN_FIFO_DEPTH = 8,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int ERR_CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 aw_valid,
   input  logic                 aw_ready,
   input  logic [7:0]           aw_len,
   input  logic [AW_INFO_W-1:0] aw_info,
   input  logic                 w_valid,
   input  logic                 w_ready,
   input  logic                 w_last,
   input  logic [W_INFO_W-1:0]  w_info,
   input  logic                 b_valid,
   input  logic                 b_ready,
   input  logic [B_INFO_W-1:0]  b_info,
   input  logic                 ar_valid,
   input  logic                 ar_ready,
   input  logic [7:0]           ar_len,
   input  logic [AR_INFO_W-1:0] ar_info,
   input  logic                 r_valid,
   input  logic                 r_ready,
   input  logic                 r_last,
   input  logic [R_INFO_W-1:0]  r_info,
   output logic                 err_valid,
   output logic [2:0]           err_chan,
   output logic [3:0]           err_code,
   output logic                 err_multi,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 err_sticky
);
   localparam int AWP = AW_INFO_W + 8;
   localparam int WP  = W_INFO_W + 1;
   localparam int ARP = AR_INFO_W + 8;
   localparam int RP  = R_INFO_W + 1;

   logic [4:0]     vld_d, vld_q, rdy_d, rdy_q;
   logic [AWP-1:0] awp_d, awp_q;
   logic [WP-1:0]  wp_d, wp_q;
   logic [B_INFO_W-1:0] bp_d, bp_q;
   logic [ARP-1:0] arp_d, arp_q;
   logic [RP-1:0]  rp_d, rp_q;
   logic [4:0]     stall, chg, to;

   always_comb begin
      vld_d = {r_valid, ar_valid, b_valid, w_valid, aw_valid};
      rdy_d = {r_ready, ar_ready, b_ready, w_ready, aw_ready};
      awp_d = {aw_len, aw_info};
      wp_d  = {w_last, w_info};
      bp_d  = b_info;
      arp_d = {ar_len, ar_info};
      rp_d  = {r_last, r_info};
      stall = vld_q & ~rdy_q;
      chg[0] = (awp_d !== awp_q);
      chg[1] = (wp_d !== wp_q);
      chg[2] = (bp_d !== bp_q);
      chg[3] = (arp_d !== arp_q);
      chg[4] = (rp_d !== rp_q);
   end

   logic aw_hs, w_hs, ar_hs, r_hs;
   assign aw_hs = aw_valid & aw_ready;
   assign w_hs  = w_valid & w_ready;
   assign ar_hs = ar_valid & ar_ready;
   assign r_hs  = r_valid & r_ready;

   logic       wf_push, wf_pop, wf_empty, wf_ovf;
   logic [7:0] wf_head;
   logic       rf_pop, rf_empty, rf_ovf;
   logic [7:0] rf_head;

   axi_handshake_monitor_len_fifo #(.DEPTH(LEN_FIFO_DEPTH)) u_wf (
      .clk(clk), .rst_n(rst_n), .push(wf_push), .din(aw_len),
      .pop(wf_pop), .empty(wf_empty), .head(wf_head), .ovf(wf_ovf)
   );

   axi_handshake_monitor_len_fifo #(.DEPTH(LEN_FIFO_DEPTH)) u_rf (
      .clk(clk), .rst_n(rst_n), .push(ar_hs), .din(ar_len),
      .pop(rf_pop), .empty(rf_empty), .head(rf_head), .ovf(rf_ovf)
   );

   // w_wait_q: a complete W burst arrived before its AW; wcnt_q holds its last-beat index
   logic       w_wait_q, w_wait_d;
   logic [8:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
   logic [8:0] aw_len9, wh9, rh9, winc, rinc;
   logic       w_e3, w_e4, r_e5, r_e6, r_e9;

   always_comb begin
      aw_len9 = {1'b0, aw_len};
      wh9  = {1'b0, wf_head};
      rh9  = {1'b0, rf_head};
      winc = (wcnt_q == 9'h1FF) ? wcnt_q : wcnt_q + 9'd1;
      rinc = (rcnt_q == 9'h1FF) ? rcnt_q : rcnt_q + 9'd1;
      wf_push  = aw_hs & ~w_wait_q;
      wf_pop   = 1'b0;
      wcnt_d   = wcnt_q;
      w_wait_d = w_wait_q;
      w_e3 = 1'b0;
      w_e4 = 1'b0;
      if (w_wait_q) begin
         // the incoming AW is consumed by the early burst, not queued
         if (aw_hs) begin
            w_e3 = (wcnt_q < aw_len9);
            w_e4 = (wcnt_q > aw_len9);
            w_wait_d = 1'b0;
            wcnt_d   = 9'd0;
            if (w_hs) begin
               if (w_last) w_wait_d = 1'b1;
               else        wcnt_d   = 9'd1;
            end
         end
      end else begin
         // early beats already ran past the length of the first AW
         if (wf_empty && aw_hs && (wcnt_q > aw_len9)) w_e4 = 1'b1;
         if (w_hs) begin
            if (!wf_empty || aw_hs) begin
               if (w_last) begin
                  wf_pop = 1'b1;
                  wcnt_d = 9'd0;
                  w_e3   = (wcnt_q < wh9);
               end else begin
                  w_e4   = (wcnt_q == wh9);
                  wcnt_d = winc;
               end
            end else if (w_last) begin
               w_wait_d = 1'b1;
            end else begin
               wcnt_d = winc;
            end
         end
      end
   end

   always_comb begin
      rf_pop = 1'b0;
      rcnt_d = rcnt_q;
      r_e5 = 1'b0;
      r_e6 = 1'b0;
      r_e9 = 1'b0;
      if (r_hs) begin
         if (rf_empty && !ar_hs) begin
            r_e9 = 1'b1;
         end else if (r_last) begin
            rf_pop = 1'b1;
            rcnt_d = 9'd0;
            r_e5   = (rcnt_q < rh9);
         end else begin
            r_e6   = (rcnt_q == rh9);
            rcnt_d = rinc;
         end
      end
   end

`ifdef AXI_MON_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TPRE = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] sc_q [5];
   logic [TW-1:0] sc_d [5];

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         sc_d[i] = '0;
         to[i]   = 1'b0;
         if (vld_d[i] && !rdy_d[i]) begin
            sc_d[i] = (sc_q[i] == TLIM) ? sc_q[i] : sc_q[i] + 1'b1;
            to[i]   = (sc_q[i] == TPRE);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 5; i++) begin
         if (!rst_n) sc_q[i] <= '0;
         else        sc_q[i] <= sc_d[i];
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign to = '0;
`endif

   logic [4:0][15:0] ev;
   logic [79:0]      ev_flat;
   logic             any;
   logic [2:0]       sel_chan;
   logic [3:0]       sel_code;

   always_comb begin
      ev = '0;
      for (int i = 0; i < 5; i++) begin
         ev[i][1] = stall[i] & ~vld_d[i];
         ev[i][2] = stall[i] & vld_d[i] & chg[i];
         ev[i][7] = to[i];
      end
      ev[0][8] = wf_ovf;
      ev[1][3] = w_e3;
      ev[1][4] = w_e4;
      ev[3][8] = rf_ovf;
      ev[4][5] = r_e5;
      ev[4][6] = r_e6;
      ev[4][9] = r_e9;
      ev_flat = ev;
      any = |ev_flat;
      sel_chan = 3'd0;
      sel_code = 4'd0;
      // descending scans so the lowest channel and code are written last
      for (int i = 4; i >= 0; i--) begin
         if (|ev[i]) begin
            sel_chan = 3'(i);
            for (int c = 15; c >= 1; c--) begin
               if (ev[i][c]) sel_code = 4'(c);
            end
         end
      end
   end

   logic                 err_valid_d, err_valid_q;
   logic [2:0]           err_chan_d, err_chan_q;
   logic [3:0]           err_code_d, err_code_q;
   logic                 err_multi_d, err_multi_q;
   logic [ERR_CNT_W-1:0] err_count_d, err_count_q;
   logic                 err_sticky_d, err_sticky_q;

   always_comb begin
      err_valid_d  = any;
      err_chan_d   = sel_chan;
      err_code_d   = sel_code;
      // x & (x-1) is nonzero exactly when two or more bits are set
      err_multi_d  = |(ev_flat & (ev_flat - 80'd1));
      err_count_d  = err_count_q;
      if (any && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
      err_sticky_d = err_sticky_q | any;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q        <= '0;
         rdy_q        <= '0;
         awp_q        <= '0;
         wp_q         <= '0;
         bp_q         <= '0;
         arp_q        <= '0;
         rp_q         <= '0;
         w_wait_q     <= 1'b0;
         wcnt_q       <= '0;
         rcnt_q       <= '0;
         err_valid_q  <= 1'b0;
         err_chan_q   <= '0;
         err_code_q   <= '0;
         err_multi_q  <= 1'b0;
         err_count_q  <= '0;
         err_sticky_q <= 1'b0;
      end else begin
         vld_q        <= vld_d;
         rdy_q        <= rdy_d;
         awp_q        <= awp_d;
         wp_q         <= wp_d;
         bp_q         <= bp_d;
         arp_q        <= arp_d;
         rp_q         <= rp_d;
         w_wait_q     <= w_wait_d;
         wcnt_q       <= wcnt_d;
         rcnt_q       <= rcnt_d;
         err_valid_q  <= err_valid_d;
         err_chan_q   <= err_chan_d;
         err_code_q   <= err_code_d;
         err_multi_q  <= err_multi_d;
         err_count_q  <= err_count_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign err_valid  = err_valid_q;
   assign err_chan   = err_chan_q;
   assign err_code   = err_code_q;
   assign err_multi  = err_multi_q;
   assign err_count  = err_count_q;
   assign err_sticky = err_sticky_q;
endmodule

// File: tb/tb_axi_handshake_monitor.sv
// Directed bench for axi_handshake_monitor.
// Inputs change after each falling edge; outputs are checked at the next falling edge.

module tb_axi_handshake_monitor;
   logic        clk, rst_n;
   logic        aw_valid, aw_ready;
   logic [7:0]  aw_len;
   logic [63:0] aw_info;
   logic        w_valid, w_ready, w_last;
   logic [35:0] w_info;
   logic        b_valid, b_ready;
   logic [9:0]  b_info;
   logic        ar_valid, ar_ready;
   logic [7:0]  ar_len;
   logic [63:0] ar_info;
   logic        r_valid, r_ready, r_last;
   logic [41:0] r_info;
   logic        err_valid, err_multi, err_sticky;
   logic [2:0]  err_chan;
   logic [3:0]  err_code;
   logic [15:0] err_count;

   int errors = 0;
   int checks = 0;
   int pulses;
   logic [2:0] p_chan;
   logic [3:0] p_code;
   int exp_cnt;

   axi_handshake_monitor #(
      .LEN_FIFO_DEPTH(8),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .aw_valid(aw_valid), .aw_ready(aw_ready),
      .aw_len(aw_len), .aw_info(aw_info),
      .w_valid(w_valid), .w_ready(w_ready),
      .w_last(w_last), .w_info(w_info),
      .b_valid(b_valid), .b_ready(b_ready), .b_info(b_info),
      .ar_valid(ar_valid), .ar_ready(ar_ready),
      .ar_len(ar_len), .ar_info(ar_info),
      .r_valid(r_valid), .r_ready(r_ready),
      .r_last(r_last), .r_info(r_info),
      .err_valid(err_valid), .err_chan(err_chan),
      .err_code(err_code), .err_multi(err_multi),
      .err_count(err_count), .err_sticky(err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic chk_err(input string tag,
                          input logic [2:0] ch,
                          input logic [3:0] code,
                          input logic multi);
      chk({tag, "_valid"}, {31'd0, err_valid}, 32'd1);
      chk({tag, "_chan"}, {29'd0, err_chan}, {29'd0, ch});
      chk({tag, "_code"}, {28'd0, err_code}, {28'd0, code});
      chk({tag, "_multi"}, {31'd0, err_multi}, {31'd0, multi});
   endtask

   task automatic chk_none(input string tag);
      chk(tag, {31'd0, err_valid}, 32'd0);
   endtask

   task automatic idle();
      aw_valid = 0; aw_ready = 0;
      w_valid = 0; w_ready = 0; w_last = 0;
      b_valid = 0; b_ready = 0;
      ar_valid = 0; ar_ready = 0;
      r_valid = 0; r_ready = 0; r_last = 0;
   endtask

   initial begin
      idle();
      aw_len = 0; aw_info = 0; w_info = 0; b_info = 0;
      ar_len = 0; ar_info = 0; r_info = 0;
      rst_n = 0;
      repeat (3) cyc();
      chk("rst_valid", {31'd0, err_valid}, 32'd0);
      chk("rst_chan", {29'd0, err_chan}, 32'd0);
      chk("rst_code", {28'd0, err_code}, 32'd0);
      chk("rst_multi", {31'd0, err_multi}, 32'd0);
      chk("rst_count", {16'd0, err_count}, 32'd0);
      chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
      rst_n = 1;

      // AW stalled, payload changes in the third cycle
      aw_valid = 1; aw_ready = 0; aw_len = 0;
      aw_info = 64'h1111;
      cyc(); chk_none("aw_stall1");
      cyc(); chk_none("aw_stall2");
      aw_info = 64'h2222;
      cyc(); chk_err("aw_chg", 3'd0, 4'h2, 1'b0);
      chk("aw_chg_cnt", {16'd0, err_count}, 32'd1);
      aw_ready = 1;
      cyc(); chk_none("aw_hs");
      chk("aw_hs_cnt", {16'd0, err_count}, 32'd1);
      chk("aw_hs_sticky", {31'd0, err_sticky}, 32'd1);
      aw_valid = 0; aw_ready = 0;
      w_valid = 1; w_ready = 1; w_last = 1;
      cyc(); chk_none("w_len0");
      idle(); cyc(); chk_none("idle1");

      // AW len=3 then four beats, last on the fourth
      aw_valid = 1; aw_ready = 1; aw_len = 3;
      cyc(); chk_none("aw3");
      aw_valid = 0; aw_ready = 0;
      w_valid = 1; w_ready = 1;
      for (int i = 0; i < 4; i++) begin
         w_last = (i == 3);
         w_info = 36'(i + 5);
         cyc(); chk_none("w4_beat");
      end
      idle();
      // AW len=3, last on the second beat
      aw_valid = 1; aw_ready = 1; aw_len = 3;
      cyc(); chk_none("aw3b");
      aw_valid = 0; aw_ready = 0;
      w_valid = 1; w_ready = 1; w_last = 0;
      cyc(); chk_none("w_early0");
      w_last = 1;
      cyc(); chk_err("w_early", 3'd1, 4'h3, 1'b0);
      idle(); cyc(); chk_none("idle2");

      // W ahead of AW, matching len=1
      w_valid = 1; w_ready = 1; w_last = 0;
      cyc(); chk_none("wfirst0");
      w_last = 1;
      cyc(); chk_none("wfirst1");
      idle();
      aw_valid = 1; aw_ready = 1; aw_len = 1;
      cyc(); chk_none("wfirst_aw1");
      idle();
      // W ahead of AW, AW len=3 exposes the early WLAST
      w_valid = 1; w_ready = 1; w_last = 0;
      cyc(); chk_none("wfirst2");
      w_last = 1;
      cyc(); chk_none("wfirst3");
      idle();
      aw_valid = 1; aw_ready = 1; aw_len = 3;
      cyc(); chk_err("wfirst_aw3", 3'd1, 4'h3, 1'b0);
      idle(); cyc(); chk_none("idle3");

      // R with nothing outstanding
      r_valid = 1; r_ready = 1; r_last = 1;
      cyc(); chk_err("r_orphan", 3'd4, 4'h9, 1'b0);
      idle();
      // nine AR pushes into an eight-deep FIFO
      ar_valid = 1; ar_ready = 1; ar_len = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(); chk_none("ar_fill");
      end
      cyc(); chk_err("ar_ovf", 3'd3, 4'h8, 1'b0);
      idle();
      r_valid = 1; r_ready = 1; r_last = 1;
      for (int i = 0; i < 8; i++) begin
         cyc(); chk_none("r_drain");
      end
      idle();
      // AR len=1 with the first beat in the same cycle, no RLAST on beat 1
      ar_valid = 1; ar_ready = 1; ar_len = 1;
      r_valid = 1; r_ready = 1; r_last = 0;
      cyc(); chk_none("r_bypass");
      ar_valid = 0; ar_ready = 0;
      cyc(); chk_err("r_missing", 3'd4, 4'h6, 1'b0);
      r_last = 1;
      cyc(); chk_none("r_late_last");
      idle(); cyc(); chk_none("idle4");

      // AR drops after a stall while W payload changes
      ar_valid = 1; ar_ready = 0; ar_len = 2;
      w_valid = 1; w_ready = 0; w_last = 1;
      w_info = 36'hA;
      cyc(); chk_none("multi_setup");
      ar_valid = 0;
      w_info = 36'hB;
      cyc(); chk_err("multi", 3'd1, 4'h2, 1'b1);
      w_ready = 1;
      cyc(); chk_none("multi_w_hs");
      idle();
      aw_valid = 1; aw_ready = 1; aw_len = 0;
      cyc(); chk_none("multi_aw");
      idle(); cyc(); chk_none("idle5");

      // B stalled for 40 cycles
      pulses = 0; p_chan = 0; p_code = 0;
      b_valid = 1; b_ready = 0; b_info = 10'h155;
      for (int k = 0; k < 40; k++) begin
         cyc();
         if (err_valid) begin
            pulses++;
            p_chan = err_chan;
            p_code = err_code;
         end
      end
      exp_cnt = 7;
`ifdef AXI_MON_TIMEOUT_EN
      chk("to_pulses", 32'(pulses), 32'd1);
      chk("to_chan", {29'd0, p_chan}, 32'd2);
      chk("to_code", {28'd0, p_code}, 32'd7);
      exp_cnt = 8;
`else
      chk("to_pulses", 32'(pulses), 32'd0);
`endif
      b_ready = 1;
      cyc(); chk_none("b_hs");
      idle(); cyc(); chk_none("idle6");

      chk("final_cnt", {16'd0, err_count}, 32'(exp_cnt));
      chk("final_sticky", {31'd0, err_sticky}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
